mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  localparam int GNT_IDX_I = 0;
  localparam int GNT_IDX_D = 1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch port and a data port.
// Request payload is never registered; the granted port's inputs are mirrored straight through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_word_addr,
  input  logic        i_read_en,
  output logic [31:0] i_read,
  output logic        i_ready,
  input  logic [29:0] d_word_addr,
  input  logic [31:0] d_write,
  input  logic [3:0]  d_write_byte_mask,
  input  logic        d_write_enable,
  input  logic        d_read_enable,
  output logic [31:0] d_read,
  output logic        d_ready,
  output logic [29:0] mem_word_addr,
  output logic [31:0] mem_write,
  output logic [3:0]  mem_write_byte_mask,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read,
  input  logic        mem_ready,
  output logic [1:0]  grant
);

  arb_state_t state, state_next;
  logic       last_grant_d, last_next;
  logic       i_req, d_req, pick_data;

  assign i_req = i_read_en;
  assign d_req = d_read_enable | d_write_enable;

  // last_grant_d = 1 means data owned the port most recently; reset favours data first.
  assign pick_data = !ROUND_ROBIN || !last_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant_d <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last_grant_d;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_next = pick_data ? GNT_D : GNT_I;
          last_next  = pick_data;
        end else if (d_req) begin
          state_next = GNT_D;
          last_next  = 1'b1;
        end else if (i_req) begin
          state_next = GNT_I;
          last_next  = 1'b0;
        end
      end
      // A dropped request before mem_ready aborts; last_grant keeps its value.
      GNT_I: if (mem_ready || !i_req) state_next = IDLE;
      GNT_D: if (mem_ready || !d_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_word_addr       = '0;
    mem_write           = '0;
    mem_write_byte_mask = '0;
    mem_write_enable    = 1'b0;
    mem_read_enable     = 1'b0;
    i_ready             = 1'b0;
    d_ready             = 1'b0;
    grant               = '0;
    case (state)
      GNT_I: begin
        grant[GNT_IDX_I] = 1'b1;
        mem_word_addr    = i_word_addr;
        mem_read_enable  = i_read_en;
        i_ready          = mem_ready;
      end
      GNT_D: begin
        grant[GNT_IDX_D]    = 1'b1;
        mem_word_addr       = d_word_addr;
        mem_write           = d_write;
        mem_write_byte_mask = d_write_byte_mask;
        mem_write_enable    = d_write_enable;
        mem_read_enable     = d_read_enable;
        d_ready             = mem_ready;
      end
      default: ;
    endcase
  end

  assign i_read = mem_read;
  assign d_read = mem_read;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a is round-robin, instance b gives data fixed priority.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] i_word_addr, d_word_addr;
  logic        i_read_en, d_write_enable, d_read_enable, mem_ready;
  logic [31:0] d_write, mem_read;
  logic [3:0]  d_write_byte_mask;

  logic [31:0] a_i_read, a_d_read, a_mem_write, b_i_read, b_d_read, b_mem_write;
  logic [29:0] a_mem_word_addr, b_mem_word_addr;
  logic [3:0]  a_mask, b_mask;
  logic        a_i_ready, a_d_ready, a_mem_we, a_mem_re;
  logic        b_i_ready, b_d_ready, b_mem_we, b_mem_re;
  logic [1:0]  a_grant, b_grant;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ROUND_ROBIN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .i_word_addr(i_word_addr), .i_read_en(i_read_en), .i_read(a_i_read), .i_ready(a_i_ready),
    .d_word_addr(d_word_addr), .d_write(d_write), .d_write_byte_mask(d_write_byte_mask),
    .d_write_enable(d_write_enable), .d_read_enable(d_read_enable),
    .d_read(a_d_read), .d_ready(a_d_ready),
    .mem_word_addr(a_mem_word_addr), .mem_write(a_mem_write), .mem_write_byte_mask(a_mask),
    .mem_write_enable(a_mem_we), .mem_read_enable(a_mem_re),
    .mem_read(mem_read), .mem_ready(mem_ready), .grant(a_grant)
  );

  mem_arbiter #(.ROUND_ROBIN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .i_word_addr(i_word_addr), .i_read_en(i_read_en), .i_read(b_i_read), .i_ready(b_i_ready),
    .d_word_addr(d_word_addr), .d_write(d_write), .d_write_byte_mask(d_write_byte_mask),
    .d_write_enable(d_write_enable), .d_read_enable(d_read_enable),
    .d_read(b_d_read), .d_ready(b_d_ready),
    .mem_word_addr(b_mem_word_addr), .mem_write(b_mem_write), .mem_write_byte_mask(b_mask),
    .mem_write_enable(b_mem_we), .mem_read_enable(b_mem_re),
    .mem_read(mem_read), .mem_ready(mem_ready), .grant(b_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [29:0] ia, input logic dre,
                               input logic dwe, input logic [29:0] da, input logic [31:0] dw,
                               input logic [3:0] dm, input logic mr);
    i_read_en         = ir;
    i_word_addr       = ia;
    d_read_enable     = dre;
    d_write_enable    = dwe;
    d_word_addr       = da;
    d_write           = dw;
    d_write_byte_mask = dm;
    mem_ready         = mr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Everything in IDLE must be zero, including readies even with mem_ready high.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_a_grant"}, {30'd0, a_grant}, 32'd0);
    checkOutput({tag, "_b_grant"}, {30'd0, b_grant}, 32'd0);
    checkOutput({tag, "_a_en"}, {30'd0, a_mem_we, a_mem_re}, 32'd0);
    checkOutput({tag, "_a_addr"}, {2'd0, a_mem_word_addr}, 32'd0);
    checkOutput({tag, "_a_wdata"}, a_mem_write, 32'd0);
    checkOutput({tag, "_a_mask"}, {28'd0, a_mask}, 32'd0);
    checkOutput({tag, "_a_rdy"}, {30'd0, a_i_ready, a_d_ready}, 32'd0);
    checkOutput({tag, "_b_rdy"}, {30'd0, b_i_ready, b_d_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 32'h1234_5678;
    applyStimulus(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b1);
    checkIdle("reset");
    checkOutput("i_read_bcast", a_i_read, 32'h1234_5678);
    checkOutput("d_read_bcast", a_d_read, 32'h1234_5678);

    // Single instruction fetch, memory answers two cycles after grant.
    applyStimulus(1'b1, 30'h100, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b0);
    tick();
    checkOutput("fetch_grant", {30'd0, a_grant}, 32'd1);
    checkOutput("fetch_addr", {2'd0, a_mem_word_addr}, 32'h100);
    checkOutput("fetch_re", {31'd0, a_mem_re}, 32'd1);
    checkOutput("fetch_wait_rdy", {30'd0, a_i_ready, a_d_ready}, 32'd0);
    tick();
    checkOutput("fetch_wait2_rdy", {30'd0, a_i_ready, a_d_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 30'h100, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b1);
    checkOutput("fetch_i_ready", {31'd0, a_i_ready}, 32'd1);
    checkOutput("fetch_d_ready", {31'd0, a_d_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b0);
    checkIdle("fetch_done");

    // Contention straight after reset: data first, then instruction on the RR instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 30'h200, 1'b0, 1'b1, 30'h300, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    tick();
    checkOutput("cont_a_grant", {30'd0, a_grant}, 32'd2);
    checkOutput("cont_b_grant", {30'd0, b_grant}, 32'd2);
    checkOutput("cont_wdata", a_mem_write, 32'hDEAD_BEEF);
    checkOutput("cont_mask", {28'd0, a_mask}, 32'b0101);
    checkOutput("cont_addr", {2'd0, a_mem_word_addr}, 32'h300);
    checkOutput("cont_we_re", {30'd0, a_mem_we, a_mem_re}, 32'b10);
    mem_ready = 1'b1;
    #1;
    checkOutput("cont_d_ready", {30'd0, a_i_ready, a_d_ready}, 32'b01);
    tick();
    mem_ready = 1'b0;
    #1;
    checkIdle("cont_gap");
    tick();
    checkOutput("cont2_a_grant", {30'd0, a_grant}, 32'd1);
    checkOutput("cont2_b_grant", {30'd0, b_grant}, 32'd2);
    checkOutput("cont2_a_we", {31'd0, a_mem_we}, 32'd0);
    checkOutput("cont2_a_wdata", a_mem_write, 32'd0);
    checkOutput("cont2_a_mask", {28'd0, a_mask}, 32'd0);
    checkOutput("cont2_a_addr", {2'd0, a_mem_word_addr}, 32'h200);
    checkOutput("cont2_b_wdata", b_mem_write, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    #1;
    checkOutput("cont2_a_rdy", {30'd0, a_i_ready, a_d_ready}, 32'b10);
    checkOutput("cont2_b_rdy", {30'd0, b_i_ready, b_d_ready}, 32'b01);
    tick();
    checkIdle("cont2_done");

    // Sustained contention with memory always ready.
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("sus%0d_a_grant", k), {30'd0, a_grant}, (k % 2 == 0) ? 32'd2 : 32'd1);
      checkOutput($sformatf("sus%0d_b_grant", k), {30'd0, b_grant}, 32'd2);
      tick();
      checkOutput($sformatf("sus%0d_gap", k), {28'd0, a_grant, b_grant}, 32'd0);
    end
    applyStimulus(1'b1, 30'h200, 1'b0, 1'b0, 30'h300, 32'd0, 4'd0, 1'b1);
    tick();
    checkOutput("ddrop_a_grant", {30'd0, a_grant}, 32'd1);
    checkOutput("ddrop_b_grant", {30'd0, b_grant}, 32'd1);
    tick();
    checkIdle("ddrop_done");

    // Reset while data owns the port with memory stalled.
    applyStimulus(1'b0, 30'd0, 1'b1, 1'b0, 30'h040, 32'd0, 4'd0, 1'b0);
    tick();
    checkOutput("rstmid_grant", {28'd0, a_grant, b_grant}, 32'b1010);
    checkOutput("rstmid_rdy", {31'd0, a_d_ready}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rstmid_idle", {28'd0, a_grant, b_grant}, 32'd0);
    mem_ready = 1'b1;
    #1;
    checkIdle("rstmid_hold");
    rst = 1'b0;
    applyStimulus(1'b1, 30'h080, 1'b1, 1'b0, 30'h040, 32'd0, 4'd0, 1'b0);
    tick();
    checkOutput("postrst_a_grant", {30'd0, a_grant}, 32'd2);
    checkOutput("postrst_b_grant", {30'd0, b_grant}, 32'd2);

    // Abort: data request drops before mem_ready; last grant must still read as data.
    applyStimulus(1'b1, 30'h080, 1'b0, 1'b0, 30'h040, 32'd0, 4'd0, 1'b0);
    checkOutput("abort_grant", {30'd0, a_grant}, 32'd2);
    checkOutput("abort_rdy_re", {30'd0, a_d_ready, a_mem_re}, 32'd0);
    tick();
    checkIdle("abort_idle");
    applyStimulus(1'b1, 30'h080, 1'b1, 1'b1, 30'h040, 32'h0BAD_F00D, 4'b1111, 1'b0);
    tick();
    checkOutput("abort_a_grant", {30'd0, a_grant}, 32'd1);
    checkOutput("abort_b_grant", {30'd0, b_grant}, 32'd2);
    checkOutput("both_en_b", {30'd0, b_mem_we, b_mem_re}, 32'b11);
    mem_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0, 1'b0);
    checkIdle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
